solution_checker: RTL and testbench
===================================

// Module: solution_checker
// PURPOSE
//  Downstream consumer of the assignment streamer. Captures the streamed 20-bit solution rows
//  (one per row index) into a local register file, then on request walks the player grid memory
//  row by row and compares each row against the stored solution.
//  Reports a solved flag, a count of wrong cells and a count of wrong rows to the game/display FSM.
// PARAMETERS
//  WIDTH         20  bits per row (one bit per cell)
//  ROWS          20  rows stored and checked; row indices 0..ROWS-1
//  READ_LATENCY  1   grid memory read latency in cycles; legal range 1..3
// PORTS
//  clk_in           in   1      system clock
//  reset_in         in   1      synchronous, active-high reset
//  sending_in       in   1      upstream streamer: assignment_in/counter_in valid this cycle
//  done_in          in   1      upstream streamer: stream complete (level, sticky upstream)
//  counter_in       in   6      row index of assignment_in
//  assignment_in    in   WIDTH  solution row bitmap
//  check_start_in   in   1      one-cycle request to run a check
//  grid_row_in      in   WIDTH  player row data, READ_LATENCY cycles after grid_addr_out
//  grid_addr_out    out  5      player grid row address
//  loaded_out       out  1      solution table holds a complete stream
//  busy_out         out  1      high in LOAD or CHECK
//  check_done_out   out  1      one-cycle pulse when results are final
//  solved_out       out  1      last check found zero wrong cells
//  wrong_cells_out  out  9      total differing bits, 0..400, saturates at 511
//  wrong_rows_out   out  5      rows with at least one differing bit, 0..20
// BEHAVIOUR
//  Reset: all outputs 0, table cleared to 0, state IDLE, valid pipeline cleared. Reset wins over
//   every other input in the same cycle, including mid-LOAD and mid-CHECK.
//  States: IDLE, LOAD, LOADED, CHECK, REPORT.
//  IDLE/LOADED -> LOAD when sending_in=1. The entry cycle clears the whole table and loaded_out.
//   The entry cycle also stores the word it sees.
//  LOAD: each cycle with sending_in=1 and counter_in<ROWS writes table[counter_in]<=assignment_in.
//   counter_in>=ROWS: the write is dropped silently. A repeated index overwrites the earlier word.
//   Unwritten rows stay 0.
//  LOAD -> LOADED on the first cycle with done_in=1 and sending_in=0; loaded_out<=1 that edge.
//  check_start_in is ignored in IDLE, LOAD, CHECK and REPORT, and accepted only in LOADED.
//  LOADED -> CHECK on check_start_in. That edge clears both counters, drives solved_out<=0 and
//   sets grid_addr_out<=0.
//  CHECK: grid_addr_out increments by 1 each cycle up to ROWS-1 and holds there.
//   A READ_LATENCY-deep valid/index shift register tags the returned data.
//   On each tagged cycle: diff = grid_row_in ^ table[idx].
//   wrong_cells += popcount(diff), saturating at 511.
//   wrong_rows += (diff != 0).
//   Counters update on the same edge that samples grid_row_in.
//  CHECK -> REPORT on the edge that consumes row ROWS-1. That edge happens ROWS+READ_LATENCY
//   cycles after the start edge.
//  REPORT, one cycle: check_done_out=1, and solved_out is set to (wrong_cells==0). Next state is
//   LOADED. Results hold until the next accepted check_start_in or reset.
//  sending_in=1 during CHECK/REPORT: the streamed word is ignored. The FSM goes to LOAD only after
//   it returns to LOADED.
//  busy_out = (state==LOAD || state==CHECK).
//  grid_addr_out is 0 outside CHECK.
// TESTING
//  Stream rows r=0..19 with word r*0x0B3 | (1<<r), then done. Result: loaded_out=1 and the table
//   matches; busy_out is 1 during the stream.
//  Check with grid equal to the table. Result: check_done_out pulses 21 cycles after start,
//   solved_out=1, wrong_cells=0, wrong_rows=0.
//  Grid row 7 has bit 3 flipped and row 12 has bits 0,1 flipped. Result: solved_out=0,
//   wrong_cells=3, wrong_rows=2.
//  Grid is all-ones against an all-zero table, so every row differs. Result: wrong_cells=400,
//   wrong_rows=20.
//  Stream contains counter_in=25 and a duplicate counter_in=4. Result: no write for index 25, and
//   row 4 holds the later word.
//  Assert reset_in at cycle 10 of CHECK. Result: the next cycle shows all outputs 0 and state
//   IDLE; a later check_start_in is ignored until a new load.
//  Repeat the test set with READ_LATENCY=3. check_done_out then pulses 23 cycles after start.

Source files
------------

// File: rtl/solution_checker.sv
// Solution checker: captures the streamed solution rows into a local table, then on
// request walks the player grid memory and reports wrong-cell / wrong-row counts.
module solution_checker #(
  parameter int WIDTH        = 20,
  parameter int ROWS         = 20,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             sending_in,
  input  logic             done_in,
  input  logic [5:0]       counter_in,
  input  logic [WIDTH-1:0] assignment_in,
  input  logic             check_start_in,
  input  logic [WIDTH-1:0] grid_row_in,
  output logic [4:0]       grid_addr_out,
  output logic             loaded_out,
  output logic             busy_out,
  output logic             check_done_out,
  output logic             solved_out,
  output logic [8:0]       wrong_cells_out,
  output logic [4:0]       wrong_rows_out
);

  localparam int PW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOADED, S_CHECK, S_REPORT} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] tbl_q [ROWS];

  logic [4:0] addr_q;
  logic       iss_done_q;
  logic [READ_LATENCY-1:0] vld_q;
  logic [4:0] idx_q [READ_LATENCY];
  logic [8:0] cells_q;
  logic [4:0] rows_q;
  logic       solved_q, done_q, loaded_q;

  logic             clr, wr_en, start, issue, tag_vld, last, load_end;
  logic [4:0]       tag_idx;
  logic [WIDTH-1:0] diff;
  logic [PW-1:0]    pop;
  logic [9:0]       cells_sum;
  logic [8:0]       cells_nx;

  // Control strobes and the compare datapath for the row returning this cycle
  always_comb begin
    clr       = sending_in && (state_q == S_IDLE || state_q == S_LOADED);
    wr_en     = sending_in && (counter_in < 6'(ROWS)) &&
                (state_q == S_IDLE || state_q == S_LOADED || state_q == S_LOAD);
    load_end  = (state_q == S_LOAD) && done_in && !sending_in;
    // A simultaneous new stream takes priority over a check request
    start     = (state_q == S_LOADED) && check_start_in && !sending_in;
    issue     = (state_q == S_CHECK) && !iss_done_q;
    tag_vld   = (state_q == S_CHECK) && vld_q[READ_LATENCY-1];
    tag_idx   = idx_q[READ_LATENCY-1];
    last      = tag_vld && (tag_idx == 5'(ROWS - 1));
    diff      = grid_row_in ^ tbl_q[tag_idx];
    pop       = '0;
    for (int b = 0; b < WIDTH; b++) pop = pop + PW'(diff[b]);
    cells_sum = {1'b0, cells_q} + 10'(pop);
    cells_nx  = cells_sum[9] ? 9'h1FF : cells_sum[8:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sending_in) state_d = S_LOAD;
      S_LOAD:   if (load_end) state_d = S_LOADED;
      S_LOADED: if (sending_in) state_d = S_LOAD;
                else if (check_start_in) state_d = S_CHECK;
      S_CHECK:  if (last) state_d = S_REPORT;
      S_REPORT: state_d = S_LOADED;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Solution table: cleared on stream entry, written by in-range row indices
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < ROWS; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (wr_en && counter_in == 6'(i)) tbl_q[i] <= assignment_in;
        else if (clr)                     tbl_q[i] <= '0;
      end
    end
  end

  // Address walker, valid/index tag pipeline and result counters
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      addr_q     <= '0;
      iss_done_q <= 1'b0;
      vld_q      <= '0;
      for (int k = 0; k < READ_LATENCY; k++) idx_q[k] <= '0;
      cells_q    <= '0;
      rows_q     <= '0;
      solved_q   <= 1'b0;
      done_q     <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      done_q   <= last;
      vld_q[0] <= issue;
      idx_q[0] <= addr_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
      if (clr)           loaded_q <= 1'b0;
      else if (load_end) loaded_q <= 1'b1;
      if (start) begin
        addr_q     <= '0;
        iss_done_q <= 1'b0;
        cells_q    <= '0;
        rows_q     <= '0;
        solved_q   <= 1'b0;
      end else if (state_q == S_CHECK) begin
        if (issue) begin
          if (addr_q == 5'(ROWS - 1)) iss_done_q <= 1'b1;
          else                        addr_q     <= addr_q + 5'd1;
        end
        if (tag_vld) begin
          cells_q <= cells_nx;
          rows_q  <= rows_q + {4'd0, |diff};
        end
        // Final row: results are frozen here and the address parks at 0
        if (last) begin
          solved_q <= (cells_nx == 9'd0);
          addr_q   <= '0;
        end
      end
    end
  end

  assign grid_addr_out   = (state_q == S_CHECK) ? addr_q : 5'd0;
  assign loaded_out      = loaded_q;
  assign busy_out        = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign check_done_out  = done_q;
  assign solved_out      = solved_q;
  assign wrong_cells_out = cells_q;
  assign wrong_rows_out  = rows_q;

endmodule

// File: tb/tb_solution_checker.sv
// Directed bench for solution_checker: one instance at read latency 1 and one at 3,
// driven by shared stimulus, each with its own grid memory model.
module tb_solution_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sending = 1'b0, done = 1'b0, check_start = 1'b0;
  logic [5:0]  counter = '0;
  logic [19:0] assignment = '0;

  logic [19:0] row1, row3, rd3a, rd3b;
  logic [4:0]  addr1, addr3, rows1, rows3;
  logic        loaded1, loaded3, busy1, busy3, cdone1, cdone3, solved1, solved3;
  logic [8:0]  cells1, cells3;

  logic [19:0] grid [20];
  logic [19:0] exp_tbl [20];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  solution_checker #(.WIDTH(20), .ROWS(20), .READ_LATENCY(1)) u_dut1 (
    .clk_in(clk), .reset_in(reset), .sending_in(sending), .done_in(done),
    .counter_in(counter), .assignment_in(assignment), .check_start_in(check_start),
    .grid_row_in(row1), .grid_addr_out(addr1), .loaded_out(loaded1), .busy_out(busy1),
    .check_done_out(cdone1), .solved_out(solved1), .wrong_cells_out(cells1),
    .wrong_rows_out(rows1));

  solution_checker #(.WIDTH(20), .ROWS(20), .READ_LATENCY(3)) u_dut3 (
    .clk_in(clk), .reset_in(reset), .sending_in(sending), .done_in(done),
    .counter_in(counter), .assignment_in(assignment), .check_start_in(check_start),
    .grid_row_in(row3), .grid_addr_out(addr3), .loaded_out(loaded3), .busy_out(busy3),
    .check_done_out(cdone3), .solved_out(solved3), .wrong_cells_out(cells3),
    .wrong_rows_out(rows3));

  // Grid memories: latency 1 and latency 3 read pipelines
  always @(posedge clk) begin
    row1 <= grid[addr1];
    rd3a <= grid[addr3];
    rd3b <= rd3a;
    row3 <= rd3b;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] word(input int r);
    logic [19:0] w;
    w = 20'(r * 20'h000B3) | (20'd1 << r);
    return w;
  endfunction

  task automatic send(input int idx, input logic [19:0] w);
    sending = 1'b1; counter = 6'(idx); assignment = w;
    tick();
  endtask

  task automatic end_stream();
    sending = 1'b0; counter = '0; assignment = '0; done = 1'b1;
    tick();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_d1"}, {9'd0, loaded1, busy1, cdone1, solved1, cells1, rows1, addr1}, 32'd0);
    chk({tag, "_d3"}, {9'd0, loaded3, busy3, cdone3, solved3, cells3, rows3, addr3}, 32'd0);
  endtask

  // Runs one check; optionally pulses sending mid-check, which must be ignored
  task automatic run_check(input string tag, input bit inject,
                           input int e_solved, input int e_cells, input int e_rows);
    int lat1, lat3;
    lat1 = 0; lat3 = 0;
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
    for (int n = 1; n <= 40 && (lat1 == 0 || lat3 == 0); n++) begin
      if (inject && n == 5) begin sending = 1'b1; counter = 6'd0; assignment = 20'hFFFFF; end
      else begin sending = 1'b0; assignment = '0; end
      tick();
      if (cdone1 && lat1 == 0) lat1 = n;
      if (cdone3 && lat3 == 0) lat3 = n;
    end
    sending = 1'b0;
    tick();
    chk({tag, "_lat1"},   lat1,    21);
    chk({tag, "_lat3"},   lat3,    23);
    chk({tag, "_solv1"},  solved1, e_solved);
    chk({tag, "_solv3"},  solved3, e_solved);
    chk({tag, "_cell1"},  cells1,  e_cells);
    chk({tag, "_cell3"},  cells3,  e_cells);
    chk({tag, "_rows1"},  rows1,   e_rows);
    chk({tag, "_rows3"},  rows3,   e_rows);
    chk({tag, "_idle"},   {busy1, busy3, cdone1, cdone3, loaded1, loaded3}, 6'b000011);
  endtask

  initial begin
    int seen;
    for (int r = 0; r < 20; r++) begin grid[r] = '0; exp_tbl[r] = '0; end
    tick(); tick();
    chk_idle_zero("reset");
    reset = 1'b0;
    tick();
    chk_idle_zero("idle");

    // Stream rows 0..19
    done = 1'b0;
    for (int r = 0; r < 20; r++) begin
      exp_tbl[r] = word(r);
      send(r, word(r));
      if (r == 0) chk("busy_stream", {busy1, busy3}, 2'b11);
    end
    end_stream();
    chk("loaded", {loaded1, loaded3, busy1, busy3}, 4'b1100);

    // Grid equal to table, with a stray streamed word during the check
    for (int r = 0; r < 20; r++) grid[r] = exp_tbl[r];
    run_check("match", 1'b1, 1, 0, 0);

    // Row 7 bit 3, row 12 bits 0 and 1 flipped
    grid[7]  = grid[7]  ^ 20'h00008;
    grid[12] = grid[12] ^ 20'h00003;
    run_check("flip3", 1'b0, 0, 3, 2);

    // Stream with an out-of-range index and a duplicate index 4
    done = 1'b0;
    for (int r = 0; r < 20; r++) send(r, word(r));
    send(25, 20'hFFFFF);
    send(4, 20'h5A5A5);
    end_stream();
    exp_tbl[4] = 20'h5A5A5;
    for (int r = 0; r < 20; r++) grid[r] = exp_tbl[r];
    run_check("dup_new", 1'b0, 1, 0, 0);
    grid[4] = word(4);
    run_check("dup_old", 1'b0, 0, 12, 1);

    // Table left all zero (only an out-of-range write); grid all ones
    done = 1'b0;
    send(25, 20'hFFFFF);
    end_stream();
    chk("zero_loaded", {loaded1, loaded3}, 2'b11);
    for (int r = 0; r < 20; r++) grid[r] = 20'hFFFFF;
    run_check("allone", 1'b0, 0, 400, 20);
    for (int r = 0; r < 20; r++) grid[r] = '0;
    run_check("allzero", 1'b0, 1, 0, 0);

    // Reset in the middle of a check
    grid[3] = 20'h00F00;
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    chk("mid_busy", {busy1, busy3}, 2'b11);
    reset = 1'b1;
    tick();
    chk_idle_zero("midrst");
    reset = 1'b0;
    tick();
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (cdone1 || cdone3 || busy1 || busy3) seen = 1;
    end
    chk("ign_start", seen, 0);
    chk_idle_zero("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
